// File: rtl/swire_pkg.sv
// Shared types and default timing for the SWIRE pulse generator.
// Optional feature macro: SWIRE_RELOAD_EN (adds the i_reload interface signal).
package swire_pkg;

  localparam int CNT_W = 6;
  localparam int TMR_W = 24;

  localparam int T_INIT_DEF = 1900;
  localparam int T_LO_DEF   = 38;
  localparam int T_HI_DEF   = 38;
  localparam int T_GAP_DEF  = 19000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_A_LO = 3'd2,
    ST_A_HI = 3'd3,
    ST_GAP  = 3'd4,
    ST_B_LO = 3'd5,
    ST_B_HI = 3'd6,
    ST_DONE = 3'd7
  } swire_state_e;

  // The phase timer counts T-1 down to 0, so a phase of T clocks loads T-1.
  function automatic logic [TMR_W-1:0] phase_load(input int t);
    return TMR_W'(t - 1);
  endfunction

endpackage

// File: rtl/swire_pulse_gen_if.sv
// Control/status bundle between the start-delay stage, the SWIRE generator and the panel pin.
// i_reload only exists when SWIRE_RELOAD_EN is defined.
interface swire_pulse_gen_if;
  import swire_pkg::*;

  logic             i_swire_start;
  logic [CNT_W-1:0] i_pulse_cnt_a;
  logic [CNT_W-1:0] i_pulse_cnt_b;
  logic             o_swire;
  logic             o_busy;
  logic             o_done;
`ifdef SWIRE_RELOAD_EN
  logic             i_reload;

  modport master (output i_swire_start, i_pulse_cnt_a, i_pulse_cnt_b, i_reload,
                  input  o_swire, o_busy, o_done);
  modport slave  (input  i_swire_start, i_pulse_cnt_a, i_pulse_cnt_b, i_reload,
                  output o_swire, o_busy, o_done);
`else
  modport master (output i_swire_start, i_pulse_cnt_a, i_pulse_cnt_b,
                  input  o_swire, o_busy, o_done);
  modport slave  (input  i_swire_start, i_pulse_cnt_a, i_pulse_cnt_b,
                  output o_swire, o_busy, o_done);
`endif
endinterface

// File: rtl/swire_phase_timer.sv
// Load/decrement phase timer; expire is high on the cycle the count reads zero.
module swire_phase_timer
  import swire_pkg::*;
(
  input  logic             i_clk_38m,
  input  logic             i_reset_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             expire
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge i_clk_38m or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TMR_W'(1);
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/swire_pulse_gen.sv
// SWIRE line sequencer: enable high, cmd A pulse train, gap, cmd B pulse train, done.
// Define SWIRE_RELOAD_EN to allow re-sending both trains from DONE via i_reload.
module swire_pulse_gen
  import swire_pkg::*;
#(
  parameter int T_INIT = T_INIT_DEF,
  parameter int T_LO   = T_LO_DEF,
  parameter int T_HI   = T_HI_DEF,
  parameter int T_GAP  = T_GAP_DEF
) (
  input  logic             i_clk_38m,
  input  logic             i_reset_n,
  swire_pulse_gen_if.slave bus
);

  swire_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q, cnt_a_d, cnt_b_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, pcnt_nx;
  logic             latch;
  logic             tmr_load, tmr_exp;
  logic [TMR_W-1:0] tmr_val;
  logic             swire_d, busy_d, done_d;

  function automatic swire_state_e first_cmd(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W-1:0] b);
    if (a != '0)      return ST_A_LO;
    else if (b != '0) return ST_B_LO;
    else              return ST_DONE;
  endfunction

  assign pcnt_nx = pcnt_q + CNT_W'(1);
  assign cnt_a_d = bus.i_pulse_cnt_a;
  assign cnt_b_d = bus.i_pulse_cnt_b;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.i_swire_start) begin
        state_d = ST_INIT;
        latch   = 1'b1;
      end
      ST_INIT: if (tmr_exp) state_d = first_cmd(cnt_a_q, cnt_b_q);
      ST_A_LO: if (tmr_exp) state_d = ST_A_HI;
      ST_A_HI: if (tmr_exp) begin
        if (pcnt_nx == cnt_a_q) begin
          pcnt_d  = '0;
          state_d = (cnt_b_q != '0) ? ST_GAP : ST_DONE;
        end else begin
          pcnt_d  = pcnt_nx;
          state_d = ST_A_LO;
        end
      end
      ST_GAP:  if (tmr_exp) state_d = ST_B_LO;
      ST_B_LO: if (tmr_exp) state_d = ST_B_HI;
      ST_B_HI: if (tmr_exp) begin
        if (pcnt_nx == cnt_b_q) begin
          pcnt_d  = '0;
          state_d = ST_DONE;
        end else begin
          pcnt_d  = pcnt_nx;
          state_d = ST_B_LO;
        end
      end
      ST_DONE: begin
`ifdef SWIRE_RELOAD_EN
        // Reload skips INIT: the line is already high and the IC already enabled.
        if (bus.i_reload) begin
          latch   = 1'b1;
          pcnt_d  = '0;
          state_d = first_cmd(bus.i_pulse_cnt_a, bus.i_pulse_cnt_b);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every state change starts a new phase, so the timer reloads from the target state.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    case (state_d)
      ST_INIT:          tmr_val = phase_load(T_INIT);
      ST_A_LO, ST_B_LO: tmr_val = phase_load(T_LO);
      ST_A_HI, ST_B_HI: tmr_val = phase_load(T_HI);
      ST_GAP:           tmr_val = phase_load(T_GAP);
      default:          tmr_val = '0;
    endcase
  end

  always_comb begin
    swire_d = !(state_d == ST_IDLE || state_d == ST_A_LO || state_d == ST_B_LO);
    busy_d  = !(state_d == ST_IDLE || state_d == ST_DONE);
    done_d  = (state_d == ST_DONE);
  end

  swire_phase_timer u_timer (
    .i_clk_38m (i_clk_38m),
    .i_reset_n (i_reset_n),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .expire    (tmr_exp)
  );

  always_ff @(posedge i_clk_38m or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      pcnt_q      <= '0;
      bus.o_swire <= 1'b0;
      bus.o_busy  <= 1'b0;
      bus.o_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      bus.o_swire <= swire_d;
      bus.o_busy  <= busy_d;
      bus.o_done  <= done_d;
      if (latch) begin
        cnt_a_q <= cnt_a_d;
        cnt_b_q <= cnt_b_d;
      end
    end
  end

endmodule

// File: tb/tb_swire_pulse_gen.sv
// Directed bench for swire_pulse_gen with short timing (T_INIT=4, T_LO=2, T_HI=3, T_GAP=5).
module tb_swire_pulse_gen;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  swire_pulse_gen_if bus ();

  swire_pulse_gen #(
    .T_INIT (4),
    .T_LO   (2),
    .T_HI   (3),
    .T_GAP  (5)
  ) dut (
    .i_clk_38m (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #13 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] lo2(input int s);
    return 64'h3 << s;
  endfunction

  // Called just after an edge with the DUT in IDLE; the next edge samples start (edge 0).
  task automatic run_seq(input logic [5:0] a, input logic [5:0] b, input int done_cyc,
                         input logic [63:0] lo, input int n_fall, input bit scramble,
                         input int abort_at);
    int   falls;
    logic prev;
    bus.i_pulse_cnt_a = a;
    bus.i_pulse_cnt_b = b;
    bus.i_swire_start = 1'b1;
    chk("c0_swire", int'(bus.o_swire), 0);
    chk("c0_busy",  int'(bus.o_busy),  0);
    chk("c0_done",  int'(bus.o_done),  0);
    prev  = 1'b0;
    falls = 0;
    for (int k = 1; k <= done_cyc + 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("swire_a%0d_b%0d_c%0d", a, b, k), int'(bus.o_swire), lo[k] ? 0 : 1);
      chk($sformatf("busy_a%0d_b%0d_c%0d", a, b, k),  int'(bus.o_busy),  (k < done_cyc) ? 1 : 0);
      chk($sformatf("done_a%0d_b%0d_c%0d", a, b, k),  int'(bus.o_done),  (k >= done_cyc) ? 1 : 0);
      if (prev && !bus.o_swire) falls++;
      prev = bus.o_swire;
      if (scramble && k == 1) begin
        bus.i_swire_start = 1'b0;
        bus.i_pulse_cnt_a = 6'h3F;
        bus.i_pulse_cnt_b = 6'h15;
      end
`ifdef SWIRE_RELOAD_EN
      if (k == 7 && k < done_cyc) bus.i_reload = 1'b1;
      if (k == 8) bus.i_reload = 1'b0;
`endif
      if (k == abort_at) begin
        #4;
        rst_n = 1'b0;
        #1;
        chk("abort_swire", int'(bus.o_swire), 0);
        chk("abort_busy",  int'(bus.o_busy),  0);
        chk("abort_done",  int'(bus.o_done),  0);
        return;
      end
    end
    chk($sformatf("falls_a%0d_b%0d", a, b), falls, n_fall);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    bus.i_swire_start = 1'b0;
    rst_n = 1'b1;
  endtask

  logic [63:0] m_32;
  logic [63:0] m_2;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.i_swire_start = 1'b0;
    bus.i_pulse_cnt_a = '0;
    bus.i_pulse_cnt_b = '0;
`ifdef SWIRE_RELOAD_EN
    bus.i_reload = 1'b0;
`endif
    m_32 = lo2(5) | lo2(10) | lo2(15) | lo2(25) | lo2(30);
    m_2  = lo2(5) | lo2(10);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_swire", int'(bus.o_swire), 0);
    chk("rst_busy",  int'(bus.o_busy),  0);
    chk("rst_done",  int'(bus.o_done),  0);
    rst_n = 1'b1;

    run_seq(6'd3, 6'd2, 35, m_32, 5, 1'b0, 0);
    do_reset();
    run_seq(6'd0, 6'd2, 15, m_2, 2, 1'b0, 0);
    do_reset();
    run_seq(6'd2, 6'd0, 15, m_2, 2, 1'b0, 0);
    do_reset();
    run_seq(6'd0, 6'd0, 5, 64'h0, 0, 1'b0, 0);

    // Async reset in the middle of cmd A, then a full replay with start still high.
    do_reset();
    run_seq(6'd3, 6'd2, 35, m_32, 5, 1'b0, 12);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_seq(6'd3, 6'd2, 35, m_32, 5, 1'b0, 0);

    // Inputs disturbed after the start edge must not alter the waveform.
    do_reset();
    run_seq(6'd3, 6'd2, 35, m_32, 5, 1'b1, 0);

`ifdef SWIRE_RELOAD_EN
    bus.i_pulse_cnt_a = 6'd1;
    bus.i_pulse_cnt_b = 6'd0;
    bus.i_reload = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      bus.i_reload = 1'b0;
      chk($sformatf("rl_swire_c%0d", k), int'(bus.o_swire), (k <= 2) ? 0 : 1);
      chk($sformatf("rl_busy_c%0d", k),  int'(bus.o_busy),  (k <= 5) ? 1 : 0);
      chk($sformatf("rl_done_c%0d", k),  int'(bus.o_done),  (k >= 6) ? 1 : 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
